en_mixcol_iter: RTL and testbench

EN_MIXCOL_ITER -- requirements
Module: en_mixcol_iter

---
 rtl/en_mixcol_iter_if.sv | 21 ++
 rtl/en_mixcol_iter.sv | 100 ++++++++++
 tb/tb_en_mixcol_iter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/en_mixcol_iter_if.sv
// Block handshake bundle: upstream valid/ready with block and bypass flag, downstream valid/ready with result.
// slave is the datapath's view; master is the driver/consumer side.
interface en_mixcol_iter_if;
    logic         iValid;
    logic         oReady;
    logic         iBypass;
    logic [127:0] iBlockIn;
    logic         oValid;
    logic         iReady;
    logic [127:0] oBlockOut;

    modport slave (
        input  iValid, iBypass, iBlockIn, iReady,
        output oReady, oValid, oBlockOut
    );

    modport master (
        output iValid, iBypass, iBlockIn, iReady,
        input  oReady, oValid, oBlockOut
    );
endinterface

// File: rtl/en_mixcol_iter.sv
// Iterative AES MixColumns: one 32-bit column mixer reused over four cycles, bypass for the final round.
// Latency: 4 CALC edges after the accept edge (bypass: DONE on the accept edge); DONE holds until iReady.
module en_mixcol_iter (
    input  logic              iClk,
    input  logic              iRst_n,
    en_mixcol_iter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e       st_q, st_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] blk_q, blk_d;
    logic [31:0]  col;
    logic [31:0]  col_mix;
    logic         rdy;
    logic         vld;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // out_r = 2*s_r ^ 3*s_(r+1) ^ s_(r+2) ^ s_(r+3), with 3*x folded as xt(x)^x
    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        return {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
                xt(s1) ^ xt(s2) ^ s2 ^ s3 ^ s0,
                xt(s2) ^ xt(s3) ^ s3 ^ s0 ^ s1,
                xt(s3) ^ xt(s0) ^ s0 ^ s1 ^ s2};
    endfunction

    always_comb begin
        case (cnt_q)
            2'd0:    col = blk_q[127:96];
            2'd1:    col = blk_q[95:64];
            2'd2:    col = blk_q[63:32];
            default: col = blk_q[31:0];
        endcase
    end

    assign col_mix = mixcol(col);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            st_q  <= IDLE;
            cnt_q <= 2'd0;
            blk_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            blk_q <= blk_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        blk_d = blk_q;
        rdy   = 1'b0;
        vld   = 1'b0;
        case (st_q)
            IDLE: begin
                rdy = 1'b1;
                if (bus.iValid) begin
                    blk_d = bus.iBlockIn;
                    cnt_d = 2'd0;
                    st_d  = bus.iBypass ? DONE : CALC;
                end
            end
            CALC: begin
                case (cnt_q)
                    2'd0:    blk_d[127:96] = col_mix;
                    2'd1:    blk_d[95:64]  = col_mix;
                    2'd2:    blk_d[63:32]  = col_mix;
                    default: blk_d[31:0]   = col_mix;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    st_d = DONE;
                end
            end
            DONE: begin
                vld = 1'b1;
                if (bus.iReady) begin
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign bus.oReady    = rdy;
    assign bus.oValid    = vld;
    assign bus.oBlockOut = blk_q;

endmodule

// File: tb/tb_en_mixcol_iter.sv
// Directed vectors, back-pressure, mid-block reset and a random regression for en_mixcol_iter.
// Expected results come from a GF(2^8) matrix-multiply model of MixColumns.
module tb_en_mixcol_iter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    en_mixcol_iter_if bus ();

    en_mixcol_iter dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Circulant matrix row r = rotate-right-by-r of {2,3,1,1}
    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [127:0] o;
        logic [7:0]   acc;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(coef[(k - r + 4) % 4], s[127 - 32*c - 8*k -: 8]);
                o[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one block, checks latency and data, then consumes it.
    task automatic run_block(input string tag, input logic [127:0] blk, input logic byp,
                             input logic [127:0] exp, input int exp_lat);
        int n;
        n = 0;
        while (!bus.oReady && n < 50) begin step(); n++; end
        chk({tag, "_rdy"}, 128'(bus.oReady), 128'd1);
        bus.iValid   = 1'b1;
        bus.iBlockIn = blk;
        bus.iBypass  = byp;
        step();
        bus.iValid = 1'b0;
        n = 0;
        while (!bus.oValid && n < 20) begin step(); n++; end
        chk({tag, "_lat"}, 128'(n), 128'(exp_lat));
        chk({tag, "_dat"}, bus.oBlockOut, exp);
        bus.iReady = 1'b1;
        step();
        bus.iReady = 1'b0;
        chk({tag, "_vld_drop"}, 128'(bus.oValid), 128'd0);
        chk({tag, "_rdy_back"}, 128'(bus.oReady), 128'd1);
    endtask

    localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] V3     = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        logic [127:0] held;
        logic [127:0] exp_q [$];
        logic [127:0] b;
        int sent, rcvd, cyc;

        checks = 0;
        errors = 0;
        rst_n        = 1'b0;
        bus.iValid   = 1'b0;
        bus.iBypass  = 1'b0;
        bus.iBlockIn = '0;
        bus.iReady   = 1'b0;
        #2;
        chk("rst_rdy", 128'(bus.oReady), 128'd1);
        chk("rst_vld", 128'(bus.oValid), 128'd0);
        chk("rst_out", bus.oBlockOut, 128'd0);
        step();
        step();
        rst_n = 1'b1;

        // Model sanity against the published vectors
        chk("model_v1", ref_mix(V1_IN), V1_OUT);
        chk("model_v2", ref_mix(V2_IN), V2_OUT);

        // Mix: oValid after the 4th edge following accept; bypass: DONE entered on the accept edge itself
        run_block("fips", V1_IN, 1'b0, V1_OUT, 4);
        run_block("vec2", V2_IN, 1'b0, V2_OUT, 4);
        run_block("byp",  V3,    1'b1, V3,     0);

        // Back-pressure, with iValid held high and a different block presented during CALC/DONE
        bus.iValid   = 1'b1;
        bus.iBypass  = 1'b0;
        bus.iBlockIn = V2_IN;
        step();
        bus.iBlockIn = V3;
        bus.iBypass  = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("bp_vld0", 128'(bus.oValid), 128'd1);
        held = bus.oBlockOut;
        chk("bp_dat0", held, V2_OUT);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_vld_hold", 128'(bus.oValid), 128'd1);
            chk("bp_dat_hold", bus.oBlockOut, V2_OUT);
        end
        bus.iValid = 1'b0;
        bus.iReady = 1'b1;
        step();
        bus.iReady = 1'b0;
        chk("bp_idle_rdy", 128'(bus.oReady), 128'd1);
        chk("bp_idle_vld", 128'(bus.oValid), 128'd0);
        step();
        chk("bp_no_load", 128'(bus.oReady), 128'd1);

        // Reset after two columns have been mixed
        bus.iValid   = 1'b1;
        bus.iBypass  = 1'b0;
        bus.iBlockIn = V1_IN;
        step();
        bus.iValid = 1'b0;
        step();
        step();
        chk("mid_vld", 128'(bus.oValid), 128'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", bus.oBlockOut, 128'd0);
        chk("mid_rst_vld", 128'(bus.oValid), 128'd0);
        chk("mid_rst_rdy", 128'(bus.oReady), 128'd1);
        step();
        chk("mid_hold_vld", 128'(bus.oValid), 128'd0);
        rst_n = 1'b1;
        run_block("rerun", V1_IN, 1'b0, V1_OUT, 4);

        // Random regression with scoreboard
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while ((sent < 1000 || rcvd < 1000) && cyc < 40000) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            bus.iBlockIn = b;
            bus.iBypass  = ($urandom_range(0, 9) < 3);
            bus.iValid   = (sent < 1000) && ($urandom_range(0, 9) < 6);
            bus.iReady   = ($urandom_range(0, 1) == 1);
            #1;
            if (bus.oValid && bus.iReady) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_dup", 128'd1, 128'd0);
                end else begin
                    chk("rnd_dat", bus.oBlockOut, exp_q.pop_front());
                end
                rcvd++;
            end
            if (bus.oReady && bus.iValid) begin
                exp_q.push_back(bus.iBypass ? b : ref_mix(b));
                sent++;
            end
            step();
            cyc++;
        end
        bus.iValid = 1'b0;
        bus.iReady = 1'b0;
        chk("rnd_sent", 128'(sent), 128'd1000);
        chk("rnd_rcvd", 128'(rcvd), 128'd1000);
        chk("rnd_left", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
